// File: rtl/shim_trigger_sequencer.sv
// Command-driven trigger sequencer for the shim DAC/ADC channel array.
// Pops 32-bit command words and issues registered one-cycle trigger pulses.
//
// state  | meaning
// IDLE   | no command in progress; next word may be popped
// SYNC   | waiting for every unmasked channel to report waiting_for_trigger
// EXPECT | counting external trigger edges on the selected source
// DELAY  | counting down a fixed number of cycles
// ERROR  | illegal command seen; frozen until reset
module shim_trigger_sequencer #(
    parameter int N_DAC_CH                = 8,
    parameter int N_ADC_CH                = 8,
    parameter int N_EXT_TRIG              = 2,
    parameter int TRIGGER_LOCKOUT_DEFAULT = 5000
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  cmd_word_rd_en,
    input  logic [31:0]           cmd_word,
    input  logic                  cmd_buf_empty,
    input  logic [N_EXT_TRIG-1:0] ext_trigger,
    input  logic [N_DAC_CH-1:0]   dac_waiting_for_trigger,
    input  logic [N_ADC_CH-1:0]   adc_waiting_for_trigger,
    output logic                  trigger_out,
    output logic                  bad_cmd,
    output logic                  busy,
    output logic [31:0]           trig_count
);

    localparam int              LP_NCH         = N_DAC_CH + N_ADC_CH;
    localparam logic [5:0]      LP_N_EXT       = 6'(N_EXT_TRIG);
    localparam logic [28:0]     LP_LOCKOUT_RST = 29'(TRIGGER_LOCKOUT_DEFAULT);

    localparam logic [2:0] OP_SYNC        = 3'd1;
    localparam logic [2:0] OP_SET_LOCKOUT = 3'd2;
    localparam logic [2:0] OP_EXPECT      = 3'd3;
    localparam logic [2:0] OP_DELAY       = 3'd4;
    localparam logic [2:0] OP_FORCE       = 3'd5;
    localparam logic [2:0] OP_SET_MASK    = 3'd6;
    localparam logic [2:0] OP_CANCEL      = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_EXPECT = 3'd2,
        ST_DELAY  = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rst_done;
    logic                  r_trig;
    logic                  r_bad_cmd;
    logic                  r_busy;
    logic [31:0]           r_trig_count;
    logic [28:0]           r_lockout;
    logic [28:0]           r_lockout_cnt;
    logic [LP_NCH-1:0]     r_mask;
    logic [23:0]           r_exp_cnt;
    logic [4:0]            r_exp_src;
    logic [28:0]           r_delay_cnt;
    logic [N_EXT_TRIG-1:0] r_ext_prev;

    logic [2:0]            w_op;
    logic [28:0]           w_val;
    logic                  w_head_valid;
    logic                  w_all_ready;
    logic [N_EXT_TRIG-1:0] w_edges;
    logic                  w_ext_hit;
    logic                  w_hit_eff;
    logic                  w_src_ok;
    logic                  w_op_done;
    logic                  w_pop;
    logic                  w_do_trig;
    logic                  w_cancel;
    logic                  w_illegal;

    assign w_op         = cmd_word[31:29];
    assign w_val        = cmd_word[28:0];
    // Hold off pops for the first cycle after reset release.
    assign w_head_valid = r_rst_done && !cmd_buf_empty;
    assign w_all_ready  = &({adc_waiting_for_trigger, dac_waiting_for_trigger} | ~r_mask);
    assign w_edges      = ext_trigger & ~r_ext_prev;
    assign w_src_ok     = ({1'b0, w_val[28:24]} < LP_N_EXT);
    assign w_hit_eff    = w_ext_hit && !w_cancel;

    always_comb begin
        w_ext_hit = 1'b0;
        for (int i = 0; i < N_EXT_TRIG; i++) begin
            if (r_exp_src == 5'(i) && w_edges[i]) begin
                w_ext_hit = 1'b1;
            end
        end
        w_ext_hit = w_ext_hit && (r_state == ST_EXPECT) && (r_lockout_cnt == '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_do_trig   = 1'b0;
        w_cancel    = 1'b0;
        w_illegal   = 1'b0;
        w_op_done   = 1'b0;

        case (r_state)
            ST_IDLE: w_op_done = 1'b1;
            ST_SYNC: begin
                if (w_all_ready) begin
                    w_op_done   = 1'b1;
                    w_do_trig   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXPECT: begin
                if (w_ext_hit) begin
                    w_do_trig = 1'b1;
                    if (r_exp_cnt == 24'd1) begin
                        w_op_done   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DELAY: begin
                if (r_delay_cnt == 29'd1) begin
                    w_op_done   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: ;
        endcase

        // The popped word overrides the completing op's next state (no bubble).
        if (w_head_valid && (r_state != ST_ERROR) && (w_op_done || w_op == OP_CANCEL)) begin
            w_pop = 1'b1;
            case (w_op)
                OP_SYNC: begin
                    if (w_all_ready) begin
                        w_do_trig   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SYNC;
                    end
                end
                OP_SET_LOCKOUT, OP_SET_MASK: w_state_nxt = ST_IDLE;
                OP_EXPECT: begin
                    if (!w_src_ok) begin
                        w_illegal   = 1'b1;
                        w_state_nxt = ST_ERROR;
                    end else if (w_val[23:0] == 24'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_EXPECT;
                    end
                end
                OP_DELAY: w_state_nxt = (w_val == '0) ? ST_IDLE : ST_DELAY;
                OP_FORCE: begin
                    w_do_trig   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                OP_CANCEL: begin
                    w_cancel    = 1'b1;
                    w_do_trig   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_illegal   = 1'b1;
                    w_state_nxt = ST_ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_rst_done    <= 1'b0;
            r_trig        <= 1'b0;
            r_bad_cmd     <= 1'b0;
            r_busy        <= 1'b0;
            r_trig_count  <= '0;
            r_lockout     <= LP_LOCKOUT_RST;
            r_lockout_cnt <= '0;
            r_mask        <= '1;
            r_exp_cnt     <= '0;
            r_exp_src     <= '0;
            r_delay_cnt   <= '0;
            r_ext_prev    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_done <= 1'b1;
            r_trig     <= w_do_trig;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_ext_prev <= ext_trigger;
            if (w_do_trig) begin
                r_trig_count <= r_trig_count + 32'd1;
            end
            if (w_illegal) begin
                r_bad_cmd <= 1'b1;
            end
            if (w_hit_eff) begin
                r_lockout_cnt <= r_lockout;
            end else if (r_lockout_cnt != '0) begin
                r_lockout_cnt <= r_lockout_cnt - 29'd1;
            end
            if (w_pop && w_op == OP_SET_LOCKOUT) begin
                r_lockout <= w_val;
            end
            if (w_pop && w_op == OP_SET_MASK) begin
                r_mask <= w_val[LP_NCH-1:0];
            end
            if (w_cancel) begin
                r_exp_cnt   <= '0;
                r_delay_cnt <= '0;
            end else begin
                if (w_pop && w_op == OP_EXPECT) begin
                    r_exp_cnt <= w_val[23:0];
                    r_exp_src <= w_val[28:24];
                end else if (w_hit_eff) begin
                    r_exp_cnt <= r_exp_cnt - 24'd1;
                end
                if (w_pop && w_op == OP_DELAY) begin
                    r_delay_cnt <= w_val;
                end else if (r_state == ST_DELAY && r_delay_cnt != '0) begin
                    r_delay_cnt <= r_delay_cnt - 29'd1;
                end
            end
        end
    end

    assign cmd_word_rd_en = w_pop;
    assign trigger_out    = r_trig;
    assign bad_cmd        = r_bad_cmd;
    assign busy           = r_busy;
    assign trig_count     = r_trig_count;

endmodule
